window_shift: RTL and testbench

WINDOW_SHIFT -- requirements
Module: window_shift

---
 rtl/window_shift.sv | 213 +++++++++++++++++++++
 tb/tb_window_shift.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_shift.sv
// -----------------------------------------------------------------------------
// window_shift
//
// Sliding FxF window generator for a raster-ordered 8-bit image. F row
// buffers hold the rows under the window; the window is presented to the
// downstream convolver (window_valid) and advanced each time it pulses
// shift_buffer. Moving down one image row reloads the oldest row buffer
// in place and rotates the logical top-row pointer instead of copying data.
//
// Parameters:
//   IMAGE_WIDTH   pixels per image row
//   IMAGE_HEIGHT  rows per frame
//   FILTER_SIZE   window edge F
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   pix_in        8-bit unsigned pixel, raster order
//   pix_valid     pix_in valid (transfer when pix_valid && pix_ready)
//   pix_ready     block accepts a pixel this cycle
//   window_out    F*F bytes, element (i,j) at bits [(i*F+j)*8 +: 8]
//   window_valid  window_out valid and stable
//   shift_buffer  one-cycle pulse: current window consumed
//   frame_done    one-cycle pulse after the last window of a frame
//   err           sticky protocol error flag
//
// Optional feature: define WINDOW_PROTOCOL_CHECK_EN to enable the sticky
// protocol checker on err. Without it err is tied to 0.
// -----------------------------------------------------------------------------
module window_shift #(
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int FILTER_SIZE  = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [7:0]                           pix_in,
    input  logic                                 pix_valid,
    output logic                                 pix_ready,
    output logic [FILTER_SIZE*FILTER_SIZE*8-1:0] window_out,
    output logic                                 window_valid,
    input  logic                                 shift_buffer,
    output logic                                 frame_done,
    output logic                                 err
);

    localparam int OUT_W = IMAGE_WIDTH - FILTER_SIZE + 1;
    localparam int OUT_H = IMAGE_HEIGHT - FILTER_SIZE + 1;
    localparam int CW    = (IMAGE_WIDTH > 1)  ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int FW    = (FILTER_SIZE > 1)  ? $clog2(FILTER_SIZE)  : 1;

    localparam logic [CW-1:0] COL_END   = CW'(IMAGE_WIDTH - 1); // last pixel of a row
    localparam logic [CW-1:0] COL_LAST  = CW'(OUT_W - 1);       // last window column
    localparam logic [RW-1:0] WROW_LAST = RW'(OUT_H - 1);       // last window row
    localparam logic [FW-1:0] ROW_END   = FW'(FILTER_SIZE - 1); // last row buffer

    typedef enum logic [2:0] {
        FILL,
        EMIT,
        SLIDE,
        LOAD_ROW,
        DONE
    } state_t;

    state_t state, state_next;

    logic [7:0]    rowbuf [FILTER_SIZE][IMAGE_WIDTH];
    logic [FW-1:0] top;       // row buffer holding window row 0
    logic [CW-1:0] col;       // window column position
    logic [RW-1:0] wrow;      // image row at top of window
    logic [FW-1:0] load_row;  // row buffer being filled during FILL
    logic [CW-1:0] load_col;  // pixel column being loaded

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        pix_ready    = 1'b0;
        window_valid = 1'b0;
        frame_done   = 1'b0;
        case (state)
            FILL: begin
                pix_ready = 1'b1;
                if (pix_valid && load_col == COL_END && load_row == ROW_END)
                    state_next = EMIT;
            end
            EMIT: begin
                window_valid = 1'b1;
                if (shift_buffer) begin
                    if (col != COL_LAST)        state_next = SLIDE;
                    else if (wrow != WROW_LAST) state_next = LOAD_ROW;
                    else                        state_next = DONE;
                end
            end
            SLIDE: state_next = EMIT;
            LOAD_ROW: begin
                pix_ready = 1'b1;
                if (pix_valid && load_col == COL_END)
                    state_next = EMIT;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // ------------------------------------------------------------- datapath
    // Pixels are only written in FILL/LOAD_ROW (pix_ready=1), so window_out
    // cannot change while EMIT holds window_valid high.
    // NOTE: the row buffers are small register arrays and must read back as
    // zero after reset, so they are cleared in the reset branch; a RAM-based
    // buffer would not be reset this way.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top      <= '0;
            col      <= '0;
            wrow     <= '0;
            load_row <= '0;
            load_col <= '0;
            for (int r = 0; r < FILTER_SIZE; r++)
                for (int c = 0; c < IMAGE_WIDTH; c++)
                    rowbuf[r][c] <= '0;
        end else begin
            case (state)
                FILL: if (pix_valid) begin
                    rowbuf[load_row][load_col] <= pix_in;
                    if (load_col == COL_END) begin
                        load_col <= '0;
                        if (load_row == ROW_END) begin
                            load_row <= '0;
                            top      <= '0;
                            col      <= '0;
                            wrow     <= '0;
                        end else begin
                            load_row <= load_row + FW'(1);
                        end
                    end else begin
                        load_col <= load_col + CW'(1);
                    end
                end
                EMIT: if (shift_buffer) begin
                    if (col != COL_LAST)        col <= col + CW'(1);
                    else if (wrow != WROW_LAST) col <= '0;
                end
                LOAD_ROW: if (pix_valid) begin
                    // The oldest row (at top) is overwritten with the new bottom row.
                    rowbuf[top][load_col] <= pix_in;
                    if (load_col == COL_END) begin
                        load_col <= '0;
                        top      <= (top == ROW_END) ? '0 : top + FW'(1);
                        wrow     <= wrow + RW'(1);
                    end else begin
                        load_col <= load_col + CW'(1);
                    end
                end
                DONE: begin
                    top      <= '0;
                    col      <= '0;
                    wrow     <= '0;
                    load_row <= '0;
                    load_col <= '0;
                end
                default: ;
            endcase
        end
    end

    // ----------------------------------------------------------- window mux
    // Window row i lives in row buffer (top+i) mod F.
    always_comb begin
        logic [FW:0]   rsum;
        logic [FW-1:0] rsel;
        logic [CW-1:0] csel;
        window_out = '0;
        rsum       = '0;
        rsel       = '0;
        csel       = '0;
        for (int i = 0; i < FILTER_SIZE; i++) begin
            rsum = {1'b0, top} + (FW+1)'(i);
            if (rsum >= (FW+1)'(FILTER_SIZE))
                rsum = rsum - (FW+1)'(FILTER_SIZE);
            rsel = rsum[FW-1:0];
            for (int j = 0; j < FILTER_SIZE; j++) begin
                csel = col + CW'(j);
                window_out[(i*FILTER_SIZE+j)*8 +: 8] = rowbuf[rsel][csel];
            end
        end
    end

    // ------------------------------------------------------ protocol check
`ifdef WINDOW_PROTOCOL_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if ((shift_buffer && !window_valid) || (pix_valid && state == EMIT))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_window_shift.sv
// -----------------------------------------------------------------------------
// tb_window_shift
//
// Directed bench for window_shift at default parameters (5x5 image, F=3).
// Pixels p(r,c) = 5r+c+1 are streamed; each window is compared against the
// values computed from that formula.
// -----------------------------------------------------------------------------
module tb_window_shift;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [71:0] window_out;
    logic        window_valid;
    logic        shift_buffer = 1'b0;
    logic        frame_done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    window_shift #(
        .IMAGE_WIDTH (5),
        .IMAGE_HEIGHT(5),
        .FILTER_SIZE (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .window_out  (window_out),
        .window_valid(window_valid),
        .shift_buffer(shift_buffer),
        .frame_done  (frame_done),
        .err         (err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected window with top-left at image position (wr, wc).
    function automatic logic [71:0] exp_window(int wr, int wc);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*8 +: 8] = 8'(5*(wr+i) + (wc+j) + 1);
        return w;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        pix_in    = v;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        pix_in    = '0;
    endtask

    // One full frame. gaps: idle cycle between fill pixels.
    // noise: illegal shift_buffer in idle/SLIDE cycles, illegal pix_valid in EMIT.
    task automatic run_frame(input string tag, input bit gaps, input bit noise);
        logic [71:0] ew;
        for (int k = 0; k < 15; k++) begin
            if (gaps && k > 0) begin
                if (noise) shift_buffer = 1'b1;
                tick();
                shift_buffer = 1'b0;
            end
            if (k == 14) begin
                n_cmp++;
                if (window_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s fill_early_valid: got %b want 0", tag, window_valid);
                end
            end
            push(8'(k + 1));
        end
        for (int wr = 0; wr < 3; wr++) begin
            for (int wc = 0; wc < 3; wc++) begin
                ew = exp_window(wr, wc);
                n_cmp++;
                if (window_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s win_valid(%0d,%0d): got %b want 1", tag, wr, wc, window_valid);
                end
                n_cmp++;
                if (window_out !== ew) begin
                    n_bad++;
                    $display("FAIL %s win(%0d,%0d): got %h want %h", tag, wr, wc, window_out, ew);
                end
                if (noise) begin
                    pix_in    = 8'hEE;
                    pix_valid = 1'b1;
                end
                tick();
                pix_valid = 1'b0;
                pix_in    = '0;
                n_cmp++;
                if (window_valid !== 1'b1 || window_out !== ew) begin
                    n_bad++;
                    $display("FAIL %s win_hold(%0d,%0d): got %b/%h want 1/%h",
                             tag, wr, wc, window_valid, window_out, ew);
                end
                shift_buffer = 1'b1;
                tick();
                shift_buffer = 1'b0;
                if (wr == 2 && wc == 2) begin
                    n_cmp++;
                    if (frame_done !== 1'b1 || window_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s done_pulse: got fd=%b wv=%b want fd=1 wv=0",
                                 tag, frame_done, window_valid);
                    end
                    tick();
                    n_cmp++;
                    if (frame_done !== 1'b0 || pix_ready !== 1'b1) begin
                        n_bad++;
                        $display("FAIL %s after_done: got fd=%b rdy=%b want fd=0 rdy=1",
                                 tag, frame_done, pix_ready);
                    end
                end else if (wc < 2) begin
                    n_cmp++;
                    if (window_valid !== 1'b0 || pix_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s slide(%0d,%0d): got wv=%b rdy=%b want wv=0 rdy=0",
                                 tag, wr, wc, window_valid, pix_ready);
                    end
                    if (noise) shift_buffer = 1'b1;
                    tick();
                    shift_buffer = 1'b0;
                end else begin
                    n_cmp++;
                    if (pix_ready !== 1'b1 || window_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s load_row(%0d): got rdy=%b wv=%b want rdy=1 wv=0",
                                 tag, wr, pix_ready, window_valid);
                    end
                    for (int c = 0; c < 5; c++)
                        push(8'(5*(wr+3) + c + 1));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_cmp++;
        if (window_out !== 72'h0) begin
            n_bad++;
            $display("FAIL reset_window: got %h want 0", window_out);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (pix_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", pix_ready);
        end
        n_cmp++;
        if (window_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", window_valid);
        end
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done: got %b want 0", frame_done);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err: got %b want 0", err);
        end
    endtask

    task automatic test_full_frame();
        run_frame("full", 1'b0, 1'b0);
    endtask

    task automatic test_gapped_fill();
        run_frame("gapped", 1'b1, 1'b0);
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 7; k++)
            push(8'(k + 101));
        rst = 1'b0;
        #4;
        n_cmp++;
        if (window_out !== 72'h0 || window_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_clear: got %h/%b want 0/0", window_out, window_valid);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (pix_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_ready: got %b want 1", pix_ready);
        end
        run_frame("midreset", 1'b0, 1'b0);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_err: got %b want 0", err);
        end
    endtask

    task automatic test_protocol();
        logic exp_err;
`ifdef WINDOW_PROTOCOL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_frame("noise", 1'b1, 1'b1);
        n_cmp++;
        if (err !== exp_err) begin
            n_bad++;
            $display("FAIL protocol_err: got %b want %b", err, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gapped_fill();
        test_reset_midframe();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
